conv_out_streamer: RTL
======================

CONV_OUT_STREAMER -- requirements
Module: conv_out_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bit width of one output element.
REQ-002 SHALL have parameter BATCH_SIZE, default 1, batches per captured tensor.
REQ-003 SHALL have parameter OUT_CHANNELS, default 1, output channels per tensor.
REQ-004 SHALL have parameter OUT_HEIGHT, default 2, output rows.
REQ-005 SHALL have parameter OUT_WIDTH, default 2, output columns.
REQ-006 SHALL derive localparam TOTAL = BATCH_SIZE*OUT_CHANNELS*OUT_HEIGHT*OUT_WIDTH and IDX_W = max(1, clog2(TOTAL)).
REQ-007 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-008 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port tensor_flat, input, TOTAL*DATA_WIDTH, convolution result; element i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port tensor_valid, input, 1, tensor_flat is complete this cycle.
REQ-011 SHALL have port tensor_ready, output, 1, block can capture a tensor.
REQ-012 SHALL have port m_data, output, DATA_WIDTH, streamed element.
REQ-013 SHALL have port m_valid, output, 1, m_data valid.
REQ-014 SHALL have port m_ready, input, 1, downstream accepts m_data.
REQ-015 SHALL have port m_last, output, 1, current element is index TOTAL-1.
REQ-016 SHALL have port m_index, output, IDX_W, flat index of current element.
REQ-017 SHALL have port overrun, output, 1, sticky: tensor_valid arrived while not ready.

Function
REQ-018 SHALL implement FSM states IDLE and STREAM; transfer = m_valid && m_ready.
REQ-019 SHALL drive tensor_ready = 1 exactly when state is IDLE.
REQ-020 SHALL, in IDLE with tensor_valid=1, register all of tensor_flat into an internal buffer, set index to 0, and enter STREAM on that edge.
REQ-021 SHALL assert m_valid on the first cycle after capture (latency 1 clock) and hold it in STREAM until the final transfer.
REQ-022 SHALL drive m_data = buffer element m_index (after Configuration processing) and m_last = (m_index == TOTAL-1).
REQ-023 SHALL keep m_data, m_index, m_last stable while m_valid=1 and m_ready=0.
REQ-024 SHALL increment m_index by 1 on each transfer when m_last=0.
REQ-025 SHALL, on a transfer with m_last=1, return to IDLE; m_valid=0 and m_index=0 the next cycle.
REQ-026 SHALL ignore tensor_valid in STREAM (buffer unchanged) and set overrun=1, held until reset.
REQ-027 SHALL treat tensor_valid coincident with the final transfer as an overrun (state is still STREAM).
REQ-028 SHALL not depend on tensor_flat after the capture edge.
REQ-029 SHALL, for TOTAL=1, assert m_last with the single element and return to IDLE after one transfer.

Reset
REQ-030 SHALL, on rst=0 at any time including mid-stream, immediately force state IDLE, m_valid=0, m_index=0, m_last=0, m_data=0, overrun=0, buffer=0, tensor_ready=1 after release.
REQ-031 SHALL, after rst rises, resume normal operation on the first clock edge.

Configuration
REQ-032 SHALL use macro CONV_OUT_RELU_EN: defined -> m_data = 0 when the element's MSB (two's-complement sign) is 1, else the element unchanged; undefined -> m_data = raw element; streaming timing identical in both builds.

Verification
REQ-033 SHALL cover basic stream: capture {0x00000001,0xFFFFFFFE,0x00000010,0x80000000}, m_ready=1 -> 4 consecutive beats, index 0..3, m_last on beat 3; data raw without macro, {0x1,0x0,0x10,0x0} with CONV_OUT_RELU_EN.
REQ-034 SHALL cover backpressure: m_ready=0 for 3 cycles at index 1 -> m_data/m_index held, no beat lost or repeated.
REQ-035 SHALL cover overrun: tensor_valid pulse during STREAM with different data -> overrun=1 sticky, streamed data equals first tensor.
REQ-036 SHALL cover mid-stream reset: rst=0 after beat 1 -> m_valid=0 and tensor_ready=1 with no clock edge required; new capture streams from index 0.
REQ-037 SHALL cover back-to-back: tensor_valid on the first IDLE cycle after m_last transfer -> captured, m_valid one cycle later, overrun stays 0.

Source files
------------

// File: rtl/conv_out_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : conv_out_streamer
//  Description : Captures a complete convolution output tensor in one cycle
//                and streams it out one element per handshake, in flat index
//                order. A new tensor can arrive while a stream is running.
//                That tensor is dropped and the sticky overrun flag is set.
//  Options     : CONV_OUT_RELU_EN - when defined, negative elements are
//                streamed as zero (ReLU). Handshake timing does not change.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_out_streamer #(
  parameter  int DATA_WIDTH   = 32,
  parameter  int BATCH_SIZE   = 1,
  parameter  int OUT_CHANNELS = 1,
  parameter  int OUT_HEIGHT   = 2,
  parameter  int OUT_WIDTH    = 2,
  localparam int TOTAL        = BATCH_SIZE * OUT_CHANNELS * OUT_HEIGHT * OUT_WIDTH,
  localparam int IDX_W        = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [TOTAL*DATA_WIDTH-1:0] tensor_flat,
  input  logic                        tensor_valid,
  output logic                        tensor_ready,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        m_last,
  output logic [IDX_W-1:0]            m_index,
  output logic                        overrun
);

  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(TOTAL - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t                r_state;
  logic                  r_valid;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_overrun;
  logic [DATA_WIDTH-1:0] r_buf [TOTAL];

  logic                  w_xfer;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_elem;
  logic [DATA_WIDTH-1:0] w_out;

  // A beat is consumed only when both sides agree. Last is qualified with
  // valid, so it reads 0 in IDLE even when TOTAL is 1.
  assign w_xfer = r_valid & m_ready;
  assign w_last = r_valid & (r_idx == c_LAST_IDX);
  assign w_elem = r_buf[r_idx];

`ifdef CONV_OUT_RELU_EN
  // ReLU: a negative two's-complement element is clamped to zero.
  assign w_out = w_elem[DATA_WIDTH-1] ? '0 : w_elem;
`else
  assign w_out = w_elem;
`endif

  // All outputs come from registers or from a mux of registers. A reset
  // assertion clears them at once, without waiting for a clock edge.
  assign tensor_ready = (r_state == S_IDLE);
  assign m_valid      = r_valid;
  assign m_index      = r_idx;
  assign m_last       = w_last;
  assign m_data       = w_out;
  assign overrun      = r_overrun;

  // Capture/stream FSM. The buffer is written only on the capture edge, so
  // tensor_flat may change freely while a stream is running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_valid   <= 1'b0;
      r_idx     <= '0;
      r_overrun <= 1'b0;
      for (int i = 0; i < TOTAL; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (tensor_valid) begin
            for (int i = 0; i < TOTAL; i++) begin
              r_buf[i] <= tensor_flat[i*DATA_WIDTH +: DATA_WIDTH];
            end
            r_idx   <= '0;
            r_valid <= 1'b1;
            r_state <= S_STREAM;
          end
        end
        S_STREAM: begin
          // The state is still STREAM on the final-transfer edge. A tensor
          // offered on that edge is therefore dropped and counts as an overrun.
          if (tensor_valid) begin
            r_overrun <= 1'b1;
          end
          if (w_xfer) begin
            if (w_last) begin
              r_valid <= 1'b0;
              r_idx   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_idx   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
